// File: rtl/div_restoring.sv
// Sequential restoring shift-subtract divider, unsigned or two's-complement.
// One operation takes WIDTH+2 edges after the accepting edge (PREP, WIDTH
// iterations, FIX). Divide-by-zero and the signed MOST_NEG / -1 case resolve
// in PREP. Results and flags stay valid until the next accepted start.
module div_restoring #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numerador,
    input  logic [WIDTH-1:0] denominador,
    output logic [WIDTH-1:0] cociente,
    output logic [WIDTH-1:0] resto,
    output logic             busy,
    output logic             finish,
    output logic             div_zero,
    output logic             overflow
);

    localparam int               CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        ITER = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] num_q;    // latched dividend
    logic [WIDTH-1:0] den_q;    // latched divisor
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] quot;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem;      // partial remainder
    logic [CW-1:0]    cnt;
    logic             sign_q;
    logic             sign_r;

    logic             den_zero;
    logic             ovf_case;
    logic             last_iter;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if ((SIGNED != 0) && v[WIDTH-1])
            return -v;
        return v;
    endfunction

    // Conditional two's-complement negation for the final sign fix-up.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? -v : v;
    endfunction

    assign den_zero  = (den_q == '0);
    assign ovf_case  = (SIGNED != 0) && (num_q == MOST_NEG) && (den_q == '1);
    assign last_iter = (cnt == LAST);
    // Shift the partial remainder left and pull in the next dividend MSB.
    assign rem_sh    = (rem << 1) | {{WIDTH{1'b0}}, quot[WIDTH-1]};
    // MSB of the trial difference is its sign: set means "restore".
    assign trial     = rem_sh - {1'b0, dvs};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state decode: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = (den_zero || ovf_case) ? IDLE : ITER;
            ITER:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and registered results/handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q    <= '0;
            den_q    <= '0;
            dvs      <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            cociente <= '0;
            resto    <= '0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            div_zero <= 1'b0;
            overflow <= 1'b0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q <= numerador;
                        den_q <= denominador;
                        busy  <= 1'b1;
                    end
                end
                PREP: begin
                    if (den_zero) begin
                        cociente <= '1;
                        resto    <= num_q;
                        div_zero <= 1'b1;
                        overflow <= 1'b0;
                        finish   <= 1'b1;
                        busy     <= 1'b0;
                    end else if (ovf_case) begin
                        cociente <= MOST_NEG;
                        resto    <= '0;
                        div_zero <= 1'b0;
                        overflow <= 1'b1;
                        finish   <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        quot   <= magnitude(num_q);
                        dvs    <= magnitude(den_q);
                        sign_q <= (SIGNED != 0) && (num_q[WIDTH-1] ^ den_q[WIDTH-1]);
                        sign_r <= (SIGNED != 0) && num_q[WIDTH-1];
                        rem    <= '0;
                        cnt    <= '0;
                    end
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (trial[WIDTH]) begin
                        rem  <= rem_sh;
                        quot <= {quot[WIDTH-2:0], 1'b0};
                    end else begin
                        rem  <= trial;
                        quot <= {quot[WIDTH-2:0], 1'b1};
                    end
                end
                FIX: begin
                    cociente <= apply_sign(quot, sign_q);
                    resto    <= apply_sign(rem[WIDTH-1:0], sign_r);
                    div_zero <= 1'b0;
                    overflow <= 1'b0;
                    finish   <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_restoring.sv
// Testbench for div_restoring: four instances (8-bit unsigned, 8-bit signed,
// 4-bit signed, 16-bit unsigned) driven from one scenario sequence.
module tb_div_restoring;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  st;
    logic [15:0] num, den;

    logic [7:0]  q_u8, r_u8, q_s8, r_s8;
    logic [3:0]  q_s4, r_s4;
    logic [15:0] q_u16, r_u16;
    logic [3:0]  bz, fn, dz, ov;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_restoring #(.WIDTH(8), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst_n), .start(st[0]), .numerador(num[7:0]), .denominador(den[7:0]),
        .cociente(q_u8), .resto(r_u8), .busy(bz[0]), .finish(fn[0]), .div_zero(dz[0]), .overflow(ov[0]));
    div_restoring #(.WIDTH(8), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst_n), .start(st[1]), .numerador(num[7:0]), .denominador(den[7:0]),
        .cociente(q_s8), .resto(r_s8), .busy(bz[1]), .finish(fn[1]), .div_zero(dz[1]), .overflow(ov[1]));
    div_restoring #(.WIDTH(4), .SIGNED(1)) u_s4 (
        .clk(clk), .rst(rst_n), .start(st[2]), .numerador(num[3:0]), .denominador(den[3:0]),
        .cociente(q_s4), .resto(r_s4), .busy(bz[2]), .finish(fn[2]), .div_zero(dz[2]), .overflow(ov[2]));
    div_restoring #(.WIDTH(16), .SIGNED(0)) u_u16 (
        .clk(clk), .rst(rst_n), .start(st[3]), .numerador(num), .denominador(den),
        .cociente(q_u16), .resto(r_u16), .busy(bz[3]), .finish(fn[3]), .div_zero(dz[3]), .overflow(ov[3]));

    function automatic logic [15:0] get_q(input int k);
        case (k)
            0:       return {8'h00, q_u8};
            1:       return {8'h00, q_s8};
            2:       return {12'h000, q_s4};
            default: return q_u16;
        endcase
    endfunction

    function automatic logic [15:0] get_r(input int k);
        case (k)
            0:       return {8'h00, r_u8};
            1:       return {8'h00, r_s8};
            2:       return {12'h000, r_s4};
            default: return r_u16;
        endcase
    endfunction

    // Reference: integer division straight from the arithmetic definition.
    task automatic ref_div(input int w, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic d, output logic o);
        longint m, sa, sb, qq, rr;
        m  = (64'sd1 <<< w) - 1;
        d  = 1'b0;
        o  = 1'b0;
        sa = longint'({48'h0, a});
        sb = longint'({48'h0, b});
        if (b == 16'h0) begin
            q = 16'(m);
            r = a;
            d = 1'b1;
        end else if (sgn) begin
            if (sa >= (64'sd1 <<< (w - 1))) sa = sa - (64'sd1 <<< w);
            if (sb >= (64'sd1 <<< (w - 1))) sb = sb - (64'sd1 <<< w);
            if (sa == -(64'sd1 <<< (w - 1)) && sb == -1) begin
                q = 16'(64'sd1 <<< (w - 1));
                r = 16'h0;
                o = 1'b1;
            end else begin
                qq = sa / sb;
                rr = sa % sb;
                q  = 16'(qq & m);
                r  = 16'(rr & m);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one operation on instance k and wait (bounded) for its finish.
    // lat counts edges after the accepting edge; bcnt counts busy samples
    // before finish. If poke_at >= 0 a second start with other operands is
    // pulsed after that many edges.
    task automatic run(input int k, input logic [15:0] a, input logic [15:0] b, input int poke_at,
                       output logic [15:0] q, output logic [15:0] r, output logic d, output logic o,
                       output int lat, output int bcnt, output bit both);
        num   = a;
        den   = b;
        st[k] = 1'b1;
        step();
        st[k] = 1'b0;
        lat   = 0;
        bcnt  = 0;
        both  = 1'b0;
        if (bz[k]) bcnt++;
        while (lat < 100) begin
            if (lat == poke_at) begin
                st[k] = 1'b1;
                num   = 16'h004d;
                den   = 16'h0003;
            end else begin
                st[k] = 1'b0;
            end
            step();
            lat++;
            if (bz[k] && fn[k]) both = 1'b1;
            if (fn[k]) break;
            if (bz[k]) bcnt++;
        end
        st[k] = 1'b0;
        q = get_q(k);
        r = get_r(k);
        d = dz[k];
        o = ov[k];
    endtask

    task automatic test_reset();
        repeat (2) step();
        for (int k = 0; k < 4; k++) begin
            checks++; if (get_q(k) !== 16'h0) begin errors++; $display("FAIL reset_q[%0d] got %0h want 0", k, get_q(k)); end
            checks++; if (get_r(k) !== 16'h0) begin errors++; $display("FAIL reset_r[%0d] got %0h want 0", k, get_r(k)); end
            checks++; if (bz[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d] got %b want 0", k, bz[k]); end
            checks++; if (fn[k] !== 1'b0) begin errors++; $display("FAIL reset_finish[%0d] got %b want 0", k, fn[k]); end
            checks++; if (dz[k] !== 1'b0) begin errors++; $display("FAIL reset_div_zero[%0d] got %b want 0", k, dz[k]); end
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_overflow[%0d] got %b want 0", k, ov[k]); end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned_basic();
        logic [15:0] q, r;
        logic d, o;
        int lat, bc;
        bit both;
        run(0, 16'd200, 16'd7, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'd28) begin errors++; $display("FAIL u200_7_q got %0d want 28", q); end
        checks++; if (r !== 16'd4) begin errors++; $display("FAIL u200_7_r got %0d want 4", r); end
        checks++; if (d !== 1'b0 || o !== 1'b0) begin errors++; $display("FAIL u200_7_flags got %b%b want 00", d, o); end
        checks++; if (lat != 10) begin errors++; $display("FAIL u200_7_latency got %0d want 10", lat); end
        checks++; if (bc != 10) begin errors++; $display("FAIL u200_7_busy_cycles got %0d want 10", bc); end
        checks++; if (both) begin errors++; $display("FAIL u200_7_busy_and_finish got 1 want 0"); end
        step();
        checks++; if (fn[0] !== 1'b0) begin errors++; $display("FAIL finish_one_cycle got %b want 0", fn[0]); end
        checks++; if (q_u8 !== 8'd28 || r_u8 !== 8'd4) begin errors++; $display("FAIL result_hold got %0d/%0d want 28/4", q_u8, r_u8); end
    endtask

    task automatic test_div_zero();
        logic [15:0] q, r;
        logic d, o;
        int lat, bc;
        bit both;
        run(0, 16'd13, 16'd0, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'h00ff) begin errors++; $display("FAIL dz_q got %0h want ff", q); end
        checks++; if (r !== 16'd13) begin errors++; $display("FAIL dz_r got %0d want 13", r); end
        checks++; if (d !== 1'b1 || o !== 1'b0) begin errors++; $display("FAIL dz_flags got %b%b want 10", d, o); end
        checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        run(0, 16'd5, 16'd9, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'd0 || r !== 16'd5) begin errors++; $display("FAIL u5_9 got %0d/%0d want 0/5", q, r); end
        checks++; if (d !== 1'b0) begin errors++; $display("FAIL dz_cleared got %b want 0", d); end
        checks++; if (lat != 10) begin errors++; $display("FAIL u5_9_latency got %0d want 10", lat); end
    endtask

    task automatic test_signed();
        logic [15:0] q, r;
        logic d, o;
        int lat, bc;
        bit both;
        run(1, 16'h0080, 16'h00ff, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'h0080 || r !== 16'h0) begin errors++; $display("FAIL s_min_m1 got %0h/%0h want 80/0", q, r); end
        checks++; if (o !== 1'b1 || d !== 1'b0) begin errors++; $display("FAIL s_min_m1_flags got ov%b dz%b want ov1 dz0", o, d); end
        checks++; if (lat != 1) begin errors++; $display("FAIL s_min_m1_latency got %0d want 1", lat); end
        run(1, 16'h00f9, 16'h0002, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'h00fd || r !== 16'h00ff) begin errors++; $display("FAIL s_m7_2 got %0h/%0h want fd/ff", q, r); end
        checks++; if (o !== 1'b0) begin errors++; $display("FAIL s_ov_cleared got %b want 0", o); end
        checks++; if (lat != 10) begin errors++; $display("FAIL s_m7_2_latency got %0d want 10", lat); end
        run(1, 16'h0007, 16'h00fe, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'h00fd || r !== 16'h0001) begin errors++; $display("FAIL s_7_m2 got %0h/%0h want fd/1", q, r); end
    endtask

    task automatic test_ignore_start();
        logic [15:0] q, r;
        logic d, o;
        int lat, bc;
        bit both;
        run(0, 16'd100, 16'd10, 2, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'd10 || r !== 16'd0) begin errors++; $display("FAIL ignore_start got %0d/%0d want 10/0", q, r); end
        checks++; if (lat != 10) begin errors++; $display("FAIL ignore_start_latency got %0d want 10", lat); end
        checks++; if (bc != 10) begin errors++; $display("FAIL ignore_start_busy got %0d want 10", bc); end
        repeat (3) step();
        checks++; if (bz[0] !== 1'b0 || q_u8 !== 8'd10) begin errors++; $display("FAIL idle_after_ignore got busy%b q%0d want busy0 q10", bz[0], q_u8); end
    endtask

    task automatic test_back_to_back();
        int lat, gap;
        num   = 16'd50;
        den   = 16'd5;
        st[0] = 1'b1;
        step();
        lat = 0;
        while (lat < 100 && fn[0] !== 1'b1) begin step(); lat++; end
        checks++; if (lat != 10) begin errors++; $display("FAIL b2b_first_latency got %0d want 10", lat); end
        checks++; if (q_u8 !== 8'd10 || r_u8 !== 8'd0) begin errors++; $display("FAIL b2b_first got %0d/%0d want 10/0", q_u8, r_u8); end
        num = 16'd90;
        den = 16'd7;
        gap = 0;
        step(); gap++;
        while (gap < 100 && fn[0] !== 1'b1) begin step(); gap++; end
        st[0] = 1'b0;
        checks++; if (gap != 11) begin errors++; $display("FAIL b2b_spacing got %0d want 11", gap); end
        checks++; if (q_u8 !== 8'd12 || r_u8 !== 8'd6) begin errors++; $display("FAIL b2b_second got %0d/%0d want 12/6", q_u8, r_u8); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [15:0] q, r;
        logic d, o;
        int lat, bc;
        bit both;
        num   = 16'd100;
        den   = 16'd3;
        st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        repeat (4) step();
        checks++; if (bz[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", bz[0]); end
        rst_n = 1'b0;
        #1;
        checks++; if (q_u8 !== 8'd0 || r_u8 !== 8'd0) begin errors++; $display("FAIL async_rst_result got %0d/%0d want 0/0", q_u8, r_u8); end
        checks++; if (bz[0] !== 1'b0 || fn[0] !== 1'b0) begin errors++; $display("FAIL async_rst_hs got busy%b fin%b want 00", bz[0], fn[0]); end
        checks++; if (dz[0] !== 1'b0 || ov[0] !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b%b want 00", dz[0], ov[0]); end
        step();
        rst_n = 1'b1;
        step();
        run(0, 16'd255, 16'd1, -1, q, r, d, o, lat, bc, both);
        checks++; if (q !== 16'd255 || r !== 16'd0) begin errors++; $display("FAIL after_rst got %0d/%0d want 255/0", q, r); end
        checks++; if (lat != 10) begin errors++; $display("FAIL after_rst_latency got %0d want 10", lat); end
    endtask

    task automatic test_random(input int k, input int w, input bit sgn, input int n);
        logic [15:0] a, b, q, r, eq, er, mask;
        logic d, o, ed, eo;
        int lat, bc, elat;
        bit both;
        mask = 16'((32'd1 << w) - 1);
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom) & mask;
            b = 16'($urandom) & mask;
            case (i % 50)
                0: begin a = sgn ? (mask >> 1) : mask; b = 16'd1; end
                1: begin b = a; if (a == 16'h0) begin a = 16'd1; b = 16'd1; end end
                2: b = 16'h0;
                3: begin a = (mask >> 1) + 16'd1; b = mask; end
                default: ;
            endcase
            ref_div(w, sgn, a, b, eq, er, ed, eo);
            elat = (ed || eo) ? 1 : w + 2;
            run(k, a, b, -1, q, r, d, o, lat, bc, both);
            checks++; if (q !== eq) begin errors++; $display("FAIL rand_q w%0d %0h/%0h got %0h want %0h", w, a, b, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL rand_r w%0d %0h/%0h got %0h want %0h", w, a, b, r, er); end
            checks++; if (d !== ed || o !== eo) begin errors++; $display("FAIL rand_flags w%0d %0h/%0h got %b%b want %b%b", w, a, b, d, o, ed, eo); end
            checks++; if (lat != elat) begin errors++; $display("FAIL rand_latency w%0d got %0d want %0d", w, lat, elat); end
            checks++; if (both) begin errors++; $display("FAIL rand_busy_and_finish w%0d got 1 want 0", w); end
        end
    endtask

    initial begin
        st  = 4'h0;
        num = 16'h0;
        den = 16'h0;
        test_reset();
        test_unsigned_basic();
        test_div_zero();
        test_signed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random(2, 4, 1'b1, 1000);
        test_random(3, 16, 1'b0, 1000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
